// File: rtl/eindopdracht_nios2_qsys_0_div_cell.sv
// Iterative radix-2 restoring divider for the Nios II A-stage: one quotient bit per clock,
// signed or unsigned, with a start/done handshake beside the mult cell.
module eindopdracht_nios2_qsys_0_div_cell #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] A_div_src1,
  input  logic [DATA_WIDTH-1:0] A_div_src2,
  input  logic                  A_div_signed,
  input  logic                  A_div_start,
  output logic                  A_div_busy,
  output logic                  A_div_done,
  output logic [DATA_WIDTH-1:0] A_div_quotient,
  output logic [DATA_WIDTH-1:0] A_div_remainder,
  output logic                  A_div_by_zero
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_dvd;
  logic [DATA_WIDTH-1:0] r_dsr;
  logic [DATA_WIDTH-1:0] r_raw;
  logic                  r_signQ;
  logic                  r_signR;
  logic [DATA_WIDTH-1:0] r_quot;
  logic [DATA_WIDTH-1:0] r_remOut;
  logic                  r_byZero;

  logic                  w_accept;
  logic                  w_neg1;
  logic                  w_neg2;
  logic [DATA_WIDTH-1:0] w_abs1;
  logic [DATA_WIDTH-1:0] w_abs2;
  logic [DATA_WIDTH:0]   w_remShift;
  logic [DATA_WIDTH:0]   w_trial;
  logic                  w_trialOk;

  assign w_accept = A_div_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_neg1   = A_div_signed & A_div_src1[DATA_WIDTH-1];
  assign w_neg2   = A_div_signed & A_div_src2[DATA_WIDTH-1];
  assign w_abs1   = w_neg1 ? -A_div_src1 : A_div_src1;
  assign w_abs2   = w_neg2 ? -A_div_src2 : A_div_src2;

  // The partial remainder is always below the divisor, so a signed (W+1)-bit difference never overflows.
  assign w_remShift = {r_rem, r_dvd[DATA_WIDTH-1]};
  assign w_trial    = w_remShift - {1'b0, r_dsr};
  assign w_trialOk  = ~w_trial[DATA_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    A_div_busy = 1'b0;
    A_div_done = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_next = CALC;
      CALC: begin
        A_div_busy = 1'b1;
        if (r_count == LAST) w_next = FIX;
      end
      FIX: begin
        A_div_busy = 1'b1;
        w_next     = DONE;
      end
      DONE: begin
        A_div_done = 1'b1;
        w_next     = w_accept ? CALC : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_raw    <= '0;
      r_signQ  <= 1'b0;
      r_signR  <= 1'b0;
      r_quot   <= '0;
      r_remOut <= '0;
      r_byZero <= 1'b0;
    end else if (w_accept) begin
      r_signQ <= A_div_signed & (A_div_src1[DATA_WIDTH-1] ^ A_div_src2[DATA_WIDTH-1]);
      r_signR <= w_neg1;
      r_dvd   <= w_abs1;
      r_dsr   <= w_abs2;
      r_raw   <= A_div_src1;
      r_rem   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        CALC: begin
          // The dividend register doubles as the quotient register as its bits shift out.
          if (w_trialOk) begin
            r_rem <= w_trial[DATA_WIDTH-1:0];
            r_dvd <= {r_dvd[DATA_WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_remShift[DATA_WIDTH-1:0];
            r_dvd <= {r_dvd[DATA_WIDTH-2:0], 1'b0};
          end
          r_count <= r_count + 1'b1;
        end
        FIX: begin
          if (r_dsr == '0) begin
            r_quot   <= '1;
            r_remOut <= r_raw;
            r_byZero <= 1'b1;
          end else begin
            r_quot   <= r_signQ ? -r_dvd : r_dvd;
            r_remOut <= r_signR ? -r_rem : r_rem;
            r_byZero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign A_div_quotient  = r_quot;
  assign A_div_remainder = r_remOut;
  assign A_div_by_zero   = r_byZero;

endmodule

// File: tb/tb_eindopdracht_nios2_qsys_0_div_cell.sv
// Bench for the iterative divider: fixed vectors, randomized operands against an arithmetic
// reference, plus handshake corner sequences (ignored start, back-to-back, reset abort).
module tb_eindopdracht_nios2_qsys_0_div_cell;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         sgn;
  logic         start;
  logic         busy;
  logic         done;
  logic [W-1:0] quot;
  logic [W-1:0] remd;
  logic         byZero;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  eindopdracht_nios2_qsys_0_div_cell #(.DATA_WIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .A_div_src1      (src1),
    .A_div_src2      (src2),
    .A_div_signed    (sgn),
    .A_div_start     (start),
    .A_div_busy      (busy),
    .A_div_done      (done),
    .A_div_quotient  (quot),
    .A_div_remainder (remd),
    .A_div_by_zero   (byZero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Truncating division, remainder follows the dividend; 64-bit math keeps MIN/-1 well defined.
  function automatic void refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                   output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa;
    longint sb;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (!s) begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      z  = 1'b0;
    end
  endfunction

  // Called at a falling edge; start is seen by the next rising edge, then the operands are scrambled.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    src1  = a;
    src2  = b;
    sgn   = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src1  = $urandom;
    src2  = $urandom;
    sgn   = 1'($urandom_range(0, 1));
  endtask

  task automatic waitDone(input int k0, output int cyc, output int busyN);
    int k;
    k     = k0;
    busyN = 0;
    while (!done && k < k0 + 60) begin
      if (busy) busyN++;
      @(negedge clk);
      k++;
    end
    cyc = done ? k - 1 : -1;
  endtask

  task automatic doOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [W-1:0] q, input logic [W-1:0] r, input logic z, input string tag);
    int cyc;
    int busyN;
    applyStimulus(a, b, s);
    waitDone(1, cyc, busyN);
    checkOutput({tag, " latency"}, cyc, 33);
    checkOutput({tag, " busyCycles"}, busyN, 33);
    checkOutput({tag, " busyInDone"}, 32'(busy), 0);
    checkOutput({tag, " quotient"}, quot, q);
    checkOutput({tag, " remainder"}, remd, r);
    checkOutput({tag, " byZero"}, 32'(byZero), 32'(z));
    @(negedge clk);
    checkOutput({tag, " donePulseWidth"}, 32'(done), 0);
    checkOutput({tag, " quotientHeld"}, quot, q);
  endtask

  initial begin
    vec_t vecs[$];
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    int           cyc;
    int           busyN;
    int           dones;

    vecs.push_back('{32'd100,       32'd7,          1'b0, 32'd14,        32'd2,        1'b0});
    vecs.push_back('{32'hFFFFFFF9,  32'd2,          1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF, 1'b0});
    vecs.push_back('{32'hFFFFFFF9,  32'd2,          1'b0, 32'h7FFFFFFC,  32'd1,        1'b0});
    vecs.push_back('{32'h80000000,  32'hFFFFFFFF,   1'b1, 32'h80000000,  32'd0,        1'b0});
    vecs.push_back('{32'hFFFFFFFF,  32'd1,          1'b0, 32'hFFFFFFFF,  32'd0,        1'b0});
    vecs.push_back('{32'h12345678,  32'd0,          1'b1, 32'hFFFFFFFF,  32'h12345678, 1'b1});
    vecs.push_back('{32'h12345678,  32'd0,          1'b0, 32'hFFFFFFFF,  32'h12345678, 1'b1});
    vecs.push_back('{32'd7,         32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,  32'd1,        1'b0});
    vecs.push_back('{32'hFFFFFFF9,  32'hFFFFFFFE,   1'b1, 32'd3,         32'hFFFFFFFF, 1'b0});
    vecs.push_back('{32'h80000000,  32'hFFFFFFFF,   1'b0, 32'd0,         32'h80000000, 1'b0});
    vecs.push_back('{32'd0,         32'd5,          1'b1, 32'd0,         32'd0,        1'b0});
    vecs.push_back('{32'd5,         32'h80000000,   1'b1, 32'd0,         32'd5,        1'b0});

    reset = 1'b1;
    start = 1'b0;
    src1  = '0;
    src2  = '0;
    sgn   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset quotient", quot, 0);
    checkOutput("reset remainder", remd, 0);
    checkOutput("reset byZero", 32'(byZero), 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) doOp(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r, vecs[i].z,
                           $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = W'($urandom_range(1, 255));
        2:       b = -W'($urandom_range(1, 255));
        default: b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(0, 1000));
      endcase
      s = 1'($urandom_range(0, 1));
      refModel(a, b, s, eq, er, ez);
      doOp(a, b, s, eq, er, ez, $sformatf("rand%0d", i));
    end

    // A start during CALC must not re-sample operands.
    applyStimulus(32'd60, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    src1  = 32'd9;
    src2  = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(11, cyc, busyN);
    checkOutput("ignoreStart latency", cyc, 33);
    checkOutput("ignoreStart quotient", quot, 32'd8);
    checkOutput("ignoreStart remainder", remd, 32'd4);

    // Back-to-back: start asserted during the done cycle is accepted.
    applyStimulus(32'd9, 32'd3, 1'b0);
    checkOutput("backToBack busy", 32'(busy), 1);
    waitDone(1, cyc, busyN);
    checkOutput("backToBack latency", cyc, 33);
    checkOutput("backToBack quotient", quot, 32'd3);
    checkOutput("backToBack remainder", remd, 32'd0);
    @(negedge clk);

    // Reset in the middle of an operation aborts it asynchronously.
    applyStimulus(32'd100, 32'd7, 1'b0);
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midReset busy", 32'(busy), 0);
    checkOutput("midReset done", 32'(done), 0);
    checkOutput("midReset quotient", quot, 0);
    checkOutput("midReset remainder", remd, 0);
    checkOutput("midReset byZero", 32'(byZero), 0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    checkOutput("noDoneAfterReset", dones, 0);
    checkOutput("idleAfterReset busy", 32'(busy), 0);
    doOp(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, "afterReset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
